// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared types, constants and sizing helper for bin2bcd_seq
package bin2bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Smallest digit count whose decimal range covers every WIDTH-bit value.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        longint unsigned pow;
        int d;
        max_val = (64'd1 << width) - 64'd1;
        pow = 64'd10;
        d = 1;
        while (pow <= max_val) begin
            pow = pow * 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// rtl/bin2bcd_seq_bcd_add3.sv - per-digit add-3 correction for double dabble
import bin2bcd_seq_pkg::*;

module bcd_add3 (
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    // A digit of 5 or more would exceed 9 after the next shift, so pre-correct it.
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, one bit per clock
import bin2bcd_seq_pkg::*;

module bin2bcd_seq #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int DISP_DIGITS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overload
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Too few digits would silently truncate large inputs; refuse to build.
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t           state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_next;
    logic [CNT_W-1:0] count;
    logic [BCD_W-1:0] bcd_next;
    logic             overload_next;

    // The binary part of the register passes through untouched; only BCD digits get corrected.
    assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3 u_add3 (
            .d (sr[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .q (sr_adj[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign sr_next  = {sr_adj[SR_W-2:0], 1'b0};
    assign bcd_next = sr_next[SR_W-1:WIDTH];

    // Any nonzero digit beyond what the display can show flags overload.
    if (DISP_DIGITS >= DIGITS) begin : g_no_overload
        assign overload_next = 1'b0;
    end else begin : g_overload
        assign overload_next = |bcd_next[BCD_W-1:BCD_DIGIT_W*DISP_DIGITS];
    end

    // Control FSM: load on accepted start, shift WIDTH times, publish result on the last shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overload <= 1'b0;
            sr       <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {{BCD_W{1'b0}}, bin};
                        count <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr    <= sr_next;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        bcd      <= bcd_next;
                        overload <= overload_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        overload;

    int checks;
    int failures;

    bin2bcd_seq #(
        .WIDTH       (8),
        .DIGITS      (3),
        .DISP_DIGITS (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overload (overload)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Pulse start for one edge with value v, then count edges until done (bounded).
    task automatic run_conv(input logic [7:0] v, output int lat);
        @(negedge clock);
        bin   = v;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        bin   = 8'hA5;
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overload !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b bcd=%h ovl=%b required 0 0 000 0",
                     busy, done, bcd, overload);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        int lat;
        logic [11:0] held;
        run_conv(8'd99, lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL latency_99 got=%0d required=8", lat);
        end
        checks++;
        if (bcd !== 12'h099 || overload !== 1'b0) begin
            failures++;
            $display("FAIL value_99 bcd=%h ovl=%b required 099 0", bcd, overload);
        end
        held = bcd;
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle done=%b required 0", done);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (bcd !== held || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_after_done bcd=%h busy=%b required %h 0", bcd, busy, held);
        end
    endtask

    task automatic test_values;
        logic [7:0]  vin  [3] = '{8'd100, 8'd255, 8'd0};
        logic [11:0] vexp [3] = '{12'h100, 12'h255, 12'h000};
        logic        vovl [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_conv(vin[i], lat);
            checks++;
            if (lat !== 8 || bcd !== vexp[i] || overload !== vovl[i]) begin
                failures++;
                $display("FAIL value_%0d lat=%0d bcd=%h ovl=%b required 8 %h %b",
                         vin[i], lat, bcd, overload, vexp[i], vovl[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clock);
        bin   = 8'hFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_reset busy=%b required 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || overload !== 1'b0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b bcd=%h ovl=%b required 0 0 000 0",
                     busy, done, bcd, overload);
        end
        @(negedge clock);
        reset = 1'b0;
        run_conv(8'd99, lat);
        checks++;
        if (lat !== 8 || bcd !== 12'h099 || overload !== 1'b0) begin
            failures++;
            $display("FAIL after_reset lat=%0d bcd=%h ovl=%b required 8 099 0", lat, bcd, overload);
        end
    endtask

    task automatic test_ignore_busy;
        int pulses;
        @(negedge clock);
        bin   = 8'd42;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                bin   = 8'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done) begin
                pulses++;
                checks++;
                if (bcd !== 12'h042 || overload !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_busy_value bcd=%h ovl=%b required 042 0", bcd, overload);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignore_busy_pulses got=%0d required=1", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int last_c;
        int guard;
        @(negedge clock);
        bin   = 8'd58;
        start = 1'b1;
        pulses = 0;
        last_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) begin
                pulses++;
                checks++;
                if (bcd !== 12'h058 || overload !== 1'b0) begin
                    failures++;
                    $display("FAIL held_value bcd=%h ovl=%b required 058 0", bcd, overload);
                end
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c !== 9) begin
                        failures++;
                        $display("FAIL held_period got=%0d required=9", c - last_c);
                    end
                end
                last_c = c;
            end
        end
        checks++;
        if (pulses < 4) begin
            failures++;
            $display("FAIL held_pulses got=%0d required>=4", pulses);
        end
        start = 1'b0;
        guard = 0;
        while ((busy || done) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL held_drain busy=%b required 0", busy);
        end
    endtask

    task automatic test_sweep;
        int lat;
        int bad;
        logic [11:0] e;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), lat);
            e = ref_bcd(v);
            checks++;
            if (lat !== 8 || bcd !== e || overload !== (v > 99)) begin
                failures++;
                bad++;
                if (bad <= 10) begin
                    $display("FAIL sweep_%0d lat=%0d bcd=%h ovl=%b required 8 %h %b",
                             v, lat, bcd, overload, e, (v > 99));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bin      = 8'd0;
        test_reset;
        test_basic;
        test_values;
        test_reset_mid;
        test_ignore_busy;
        test_back_to_back;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
